// File: rtl/timer_counter_ext.sv
// Multi-word up/down timer counter with byte-strobed writes, compare register,
// free-run/periodic/one-shot modes and sticky match/overflow flags.
module timer_counter_ext #(
    parameter int                        NUM_WORDS = 2,
    parameter logic [32*NUM_WORDS-1:0]   CNT_RST   = '0,
    parameter logic [32*NUM_WORDS-1:0]   CMP_RST   = '1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cnt_en,
    input  logic                         halt,
    input  logic                         timer_en_neg,
    input  logic [3:0]                   pstrb,
    input  logic [31:0]                  wdata,
    input  logic [NUM_WORDS-1:0]         cnt_wr_sel,
    input  logic [NUM_WORDS-1:0]         cmp_wr_sel,
    input  logic                         dir,
    input  logic [1:0]                   mode,
    input  logic [1:0]                   int_en,
    input  logic [1:0]                   int_clr,
    output logic [32*NUM_WORDS-1:0]      cnt,
    output logic [32*NUM_WORDS-1:0]      cmp,
    output logic                         match_flag,
    output logic                         ovf_flag,
    output logic                         done,
    output logic                         irq
);

    localparam int CNT_W = 32 * NUM_WORDS;

    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;

    logic             tick;
    logic             at_match;
    logic             at_bound;
    logic             is_oneshot;
    logic             cnt_wr_any;
    logic [CNT_W-1:0] cnt_calc;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cmp_nxt;

    // Value the counter takes on a tick; "hit" is the reload/stop point for the direction.
    function automatic logic [CNT_W-1:0] next_value(
        input logic [CNT_W-1:0] c,
        input logic [CNT_W-1:0] k,
        input logic [1:0]       m,
        input logic             d
    );
        logic             hit;
        logic [CNT_W-1:0] res;
        hit = d ? (c == '0) : (c == k);
        res = d ? (c - 1'b1) : (c + 1'b1);
        case (m)
            MODE_PERIODIC: if (hit) res = d ? k : '0;
            MODE_ONESHOT:  if (hit) res = c;
            default:       ;
        endcase
        return res;
    endfunction

    always_comb begin
        tick       = cnt_en & ~halt & ~done;
        at_match   = (cnt == cmp);
        at_bound   = dir ? (cnt == '0) : (&cnt);
        is_oneshot = (mode == MODE_ONESHOT);
        cnt_calc   = next_value(cnt, cmp, mode, dir);
    end

    // Per-byte priority: written byte, then disable clear, then tick, else hold.
    always_comb begin
        cnt_nxt    = cnt;
        cmp_nxt    = cmp;
        cnt_wr_any = 1'b0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (cnt_wr_sel[w] & pstrb[b]) begin
                    cnt_nxt[w*32 + b*8 +: 8] = wdata[b*8 +: 8];
                    cnt_wr_any               = 1'b1;
                end else if (timer_en_neg) begin
                    cnt_nxt[w*32 + b*8 +: 8] = 8'h00;
                end else if (tick) begin
                    cnt_nxt[w*32 + b*8 +: 8] = cnt_calc[w*32 + b*8 +: 8];
                end
                if (cmp_wr_sel[w] & pstrb[b]) begin
                    cmp_nxt[w*32 + b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= CNT_RST;
            cmp        <= CMP_RST;
            match_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            done       <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            cmp <= cmp_nxt;

            if (tick & at_match) begin
                match_flag <= 1'b1;
            end else if (int_clr[0]) begin
                match_flag <= 1'b0;
            end

            if (tick & at_bound & ~is_oneshot) begin
                ovf_flag <= 1'b1;
            end else if (int_clr[1]) begin
                ovf_flag <= 1'b0;
            end

            if (cnt_wr_any | timer_en_neg) begin
                done <= 1'b0;
            end else if (tick & is_oneshot & (dir ? at_bound : at_match)) begin
                done <= 1'b1;
            end
        end
    end

    assign irq = (match_flag & int_en[0]) | (ovf_flag & int_en[1]);

endmodule

// File: tb/tb_timer_counter_ext.sv
// Bench for timer_counter_ext: 64-bit and 32-bit instances driven in parallel,
// directed plan steps followed by random traffic against a behavioural model.
module tb_timer_counter_ext;

    logic        clk = 1'b0;
    logic        rst_n, cnt_en, halt, timer_en_neg, dir;
    logic [3:0]  pstrb;
    logic [31:0] wdata;
    logic [1:0]  cnt_wr_sel, cmp_wr_sel, mode, int_en, int_clr;

    logic [63:0] cnt2, cmp2;
    logic [31:0] cnt1, cmp1;
    logic        match2, ovf2, done2, irq2;
    logic        match1, ovf1, done1, irq1;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_cnt [2];
    logic [63:0] m_cmp [2];
    bit          m_match [2];
    bit          m_ovf [2];
    bit          m_done [2];

    logic [63:0] per_seq [5] = '{64'd1, 64'd2, 64'd3, 64'd0, 64'd1};

    always #5 clk = ~clk;

    timer_counter_ext #(.NUM_WORDS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .halt(halt),
        .timer_en_neg(timer_en_neg), .pstrb(pstrb), .wdata(wdata),
        .cnt_wr_sel(cnt_wr_sel), .cmp_wr_sel(cmp_wr_sel), .dir(dir),
        .mode(mode), .int_en(int_en), .int_clr(int_clr),
        .cnt(cnt2), .cmp(cmp2), .match_flag(match2), .ovf_flag(ovf2),
        .done(done2), .irq(irq2)
    );

    timer_counter_ext #(.NUM_WORDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .halt(halt),
        .timer_en_neg(timer_en_neg), .pstrb(pstrb), .wdata(wdata),
        .cnt_wr_sel(cnt_wr_sel[0:0]), .cmp_wr_sel(cmp_wr_sel[0:0]), .dir(dir),
        .mode(mode), .int_en(int_en), .int_clr(int_clr),
        .cnt(cnt1), .cmp(cmp1), .match_flag(match1), .ovf_flag(ovf1),
        .done(done1), .irq(irq1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: start from the tick/clear result, then overlay written bytes on top.
    task automatic model_step(input int i);
        logic [63:0] mask, c, k, nx, nc, nk;
        bit          tick, hit, wr, one, per;
        int          nw;
        nw   = (i == 0) ? 2 : 1;
        mask = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (!rst_n) begin
            m_cnt[i] = 64'd0;  m_cmp[i] = mask;
            m_match[i] = 0;    m_ovf[i] = 0;    m_done[i] = 0;
            return;
        end
        c    = m_cnt[i];
        k    = m_cmp[i];
        per  = (mode == 2'b01);
        one  = (mode == 2'b10);
        tick = cnt_en && !halt && !m_done[i];
        hit  = dir ? (c == 64'd0) : (c == k);
        if (!dir) nx = (per && hit) ? 64'd0 : (one && hit) ? c : ((c + 64'd1) & mask);
        else      nx = (per && hit) ? k     : (one && hit) ? c : ((c - 64'd1) & mask);
        nc = timer_en_neg ? 64'd0 : (tick ? nx : c);
        nk = k;
        wr = 0;
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (cnt_wr_sel[w] && pstrb[b]) begin
                    nc[w*32 + b*8 +: 8] = wdata[b*8 +: 8];
                    wr = 1;
                end
                if (cmp_wr_sel[w] && pstrb[b]) nk[w*32 + b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        m_match[i] = (tick && c == k) ? 1'b1 : (int_clr[0] ? 1'b0 : m_match[i]);
        m_ovf[i]   = (tick && !one && (dir ? (c == 64'd0) : (c == mask))) ? 1'b1
                   : (int_clr[1] ? 1'b0 : m_ovf[i]);
        if (wr || timer_en_neg)      m_done[i] = 0;
        else if (tick && one && hit) m_done[i] = 1;
        m_cnt[i] = nc;
        m_cmp[i] = nk;
    endtask

    task automatic compare_all();
        chk("cnt64",   cnt2,   m_cnt[0]);
        chk("cmp64",   cmp2,   m_cmp[0]);
        chk("match64", match2, m_match[0]);
        chk("ovf64",   ovf2,   m_ovf[0]);
        chk("done64",  done2,  m_done[0]);
        chk("irq64",   irq2,   (m_match[0] && int_en[0]) || (m_ovf[0] && int_en[1]));
        chk("cnt32",   cnt1,   m_cnt[1]);
        chk("cmp32",   cmp1,   m_cmp[1]);
        chk("match32", match1, m_match[1]);
        chk("ovf32",   ovf1,   m_ovf[1]);
        chk("done32",  done1,  m_done[1]);
        chk("irq32",   irq1,   (m_match[1] && int_en[0]) || (m_ovf[1] && int_en[1]));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic quiet();
        rst_n = 1'b1;  cnt_en = 1'b0;  halt = 1'b0;  timer_en_neg = 1'b0;
        pstrb = 4'h0;  wdata = 32'h0;  cnt_wr_sel = 2'b00;  cmp_wr_sel = 2'b00;
        int_clr = 2'b00;
    endtask

    initial begin
        quiet();
        dir = 1'b0;  mode = 2'b00;  int_en = 2'b00;
        @(negedge clk);

        // Reset overrides a tick and writes
        rst_n = 1'b0;  cnt_en = 1'b1;  cnt_wr_sel = 2'b11;  cmp_wr_sel = 2'b11;
        pstrb = 4'hF;  wdata = 32'h1234_5678;
        step();
        chk("rst_cnt",   cnt2, 64'h0);
        chk("rst_cmp",   cmp2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_flags", {match2, ovf2, done2, irq2}, 64'h0);

        // Byte write on word1 while word0 ticks
        quiet();  cnt_wr_sel = 2'b01;  pstrb = 4'hF;  wdata = 32'd5;
        step();
        quiet();  cnt_en = 1'b1;  cnt_wr_sel = 2'b10;  pstrb = 4'b0101;  wdata = 32'hAABB_CCDD;
        step();
        chk("byte_wr", cnt2, 64'h00BB_00DD_0000_0006);

        // Free-run up overflow on both widths
        quiet();  cnt_wr_sel = 2'b01;  pstrb = 4'hF;  wdata = 32'hFFFF_FFFE;
        step();
        cnt_wr_sel = 2'b10;  wdata = 32'hFFFF_FFFF;
        step();
        quiet();  cnt_en = 1'b1;
        step();
        chk("ovf_a64",  cnt2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf_a32",  cnt1, 64'hFFFF_FFFF);
        chk("ovf_pre",  ovf2, 64'h0);
        step();
        chk("ovf_b64",  cnt2, 64'h0);
        chk("ovf_b32",  cnt1, 64'h0);
        chk("ovf_flag", ovf2, 64'h1);
        chk("ovf_f32",  ovf1, 64'h1);
        chk("irq_off",  irq2, 64'h0);
        quiet();  int_en = 2'b10;
        step();
        chk("irq_on",   irq2, 64'h1);
        quiet();  int_en = 2'b00;  int_clr = 2'b11;
        step();
        chk("clr_flags", {match2, ovf2}, 64'h0);

        // Periodic up with cmp=3
        quiet();  cmp_wr_sel = 2'b01;  pstrb = 4'hF;  wdata = 32'd3;
        step();
        cmp_wr_sel = 2'b10;  cnt_wr_sel = 2'b11;  wdata = 32'd0;
        step();
        quiet();  mode = 2'b01;  cnt_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("per_seq",   cnt2,   per_seq[i]);
            chk("per_match", match2, (i >= 3) ? 64'h1 : 64'h0);
        end
        quiet();  int_clr = 2'b01;
        step();
        chk("per_clr", match2, 64'h0);
        quiet();  cnt_en = 1'b1;
        step();
        step();
        chk("per_at3", cnt2, 64'd3);
        int_clr = 2'b01;
        step();
        chk("per_wrap",   cnt2,   64'd0);
        chk("set_wins",   match2, 64'h1);

        // One-shot down from 2
        quiet();  mode = 2'b10;  dir = 1'b1;  cnt_wr_sel = 2'b01;  pstrb = 4'hF;  wdata = 32'd2;
        step();
        quiet();  cnt_en = 1'b1;
        step();
        chk("os_1", cnt2, 64'd1);
        step();
        chk("os_0", cnt2, 64'd0);
        chk("os_notdone", done2, 64'h0);
        step();
        chk("os_hold", cnt2, 64'd0);
        chk("os_done", done2, 64'h1);
        chk("os_noovf", ovf2, 64'h0);
        step();
        chk("os_stay", cnt2, 64'd0);
        cnt_wr_sel = 2'b01;  pstrb = 4'hF;  wdata = 32'd5;
        step();
        chk("os_wr",     cnt2,  64'd5);
        chk("os_rearm",  done2, 64'h0);
        quiet();  cnt_en = 1'b1;
        step();
        chk("os_resume", cnt2, 64'd4);

        // Halt freezes, disable pulse clears counter only
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt", cnt2, 64'd4);
        end
        quiet();  timer_en_neg = 1'b1;
        step();
        chk("dis_cnt", cnt2, 64'd0);
        chk("dis_cmp", cmp2, 64'd3);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            cnt_en       = ($urandom_range(0, 3) != 0);
            halt         = ($urandom_range(0, 7) == 0);
            timer_en_neg = ($urandom_range(0, 31) == 0);
            dir          = 1'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            int_en       = 2'($urandom);
            int_clr      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            cnt_wr_sel   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            cmp_wr_sel   = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            pstrb        = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       wdata = 32'h0;
                1:       wdata = 32'hFFFF_FFFF;
                2:       wdata = $urandom_range(0, 6);
                default: wdata = $urandom;
            endcase
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_counter_ext.md
# timer_counter_ext

Parametrised successor of the 64-bit timer counter: a counter of `NUM_WORDS`×32 bits with byte-strobed APB writes, up/down counting, a writable compare register, and free-run, periodic and one-shot modes. It sits between the register block, which supplies the write selects, tick and control, and the interrupt logic, which consumes the sticky flags and `irq`.

## Interface
- `NUM_WORDS`, 2: number of 32-bit words; legal 1..4; CNT_W = 32*NUM_WORDS.
- `CNT_RST`, 0: counter reset value, CNT_W bits.
- `CMP_RST`, all-ones: compare reset value, CNT_W bits.

- `clk` in 1: clock; one clock; all state changes on rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `cnt_en` in 1: count tick, one cycle per increment.
- `halt` in 1: debug freeze; ticks ignored while 1.
- `timer_en_neg` in 1: timer-disable pulse; clears counter.
- `pstrb` in 4: APB byte strobes.
- `wdata` in 32: APB write data.
- `cnt_wr_sel` in NUM_WORDS: one-hot counter word write select.
- `cmp_wr_sel` in NUM_WORDS: one-hot compare word write select.
- `dir` in 1: 0 = up, 1 = down.
- `mode` in 2: 00 free-run, 01 periodic, 10 one-shot, 11 treated as free-run.
- `int_en` in 2: [0] match interrupt enable, [1] overflow interrupt enable.
- `int_clr` in 2: [0] clears `match_flag`, [1] clears `ovf_flag`.
- `cnt` out CNT_W: counter value.
- `cmp` out CNT_W: compare value.
- `match_flag` out 1: sticky compare-match flag.
- `ovf_flag` out 1: sticky wrap/reload flag.
- `done` out 1: one-shot complete.
- `irq` out 1: `(match_flag & int_en[0]) | (ovf_flag & int_en[1])`.

## Operation
- tick = `cnt_en & ~halt & ~done`.
- boundary: up = `cnt` all-ones; down = `cnt` zero.
- Next `cnt`, evaluated per byte, highest priority first:
  1. Byte written: `cnt_wr_sel[w] & pstrb[b]` loads the `wdata` byte.
  2. `timer_en_neg`: byte cleared to 0.
  3. tick: byte of the computed next value.
  4. Otherwise hold.
- Unwritten bytes keep their count/clear behaviour in a write cycle.
- Computed next value on tick:
  - Free-run: `cnt±1` modulo 2^CNT_W.
  - Periodic up: `cnt==cmp` gives 0, else `cnt+1`.
  - Periodic down: `cnt==0` gives `cmp`, else `cnt-1`.
  - One-shot up: `cnt==cmp` holds `cnt` and sets `done`, else `cnt+1`.
  - One-shot down: `cnt==0` holds and sets `done`, else `cnt-1`.
- `cmp` bytes load from `wdata` on `cmp_wr_sel[w] & pstrb[b]`, otherwise hold.
  - `cmp` is unaffected by `timer_en_neg`.
- `match_flag` set on tick & `cnt==cmp` in any mode/direction.
- `ovf_flag` set on tick & boundary when mode ≠ one-shot.
- Set wins over a same-cycle `int_clr`.
- `done` cleared by any counter byte write or `timer_en_neg`; otherwise sticky.
- All comparisons use the register values before the edge.
- Writes and `mode`/`dir` changes take effect at the next edge/tick; no synchronisation required.
- A `cnt` written above `cmp` in periodic up counts to all-ones, wraps to 0 and sets `ovf_flag`.

## Timing
- Reset values: `cnt`=CNT_RST, `cmp`=CMP_RST, `match_flag`=0, `ovf_flag`=0, `done`=0, `irq`=0.
- Reset applies on the first rising edge with `rst_n`=0 and overrides all other inputs.
- Latency from tick to `cnt` update: 1 cycle.
- Flags and `done` register on the same edge as the `cnt` update.
- `irq` is combinational from the flags and `int_en`: no added latency.
- Back-to-back ticks count every cycle.
- `halt`, or `done`=1, blocks counting and flag setting; writes still apply.
- Simultaneous `timer_en_neg` and counter write: written bytes take `wdata`, the rest clear.
- Reset mid-count returns everything to reset values on that edge; no partial state survives.

## Test plan
- Reset, NUM_WORDS=2:
  - Assert `rst_n`=0 with `cnt_en`=1 and a write active -> after the edge `cnt`=0, `cmp`=FFFF_FFFF_FFFF_FFFF, all flags 0.
- Byte write with counting:
  - Write word1 `wdata`=0xAABBCCDD, `pstrb`=0101 while ticking from `cnt`=0x0000_0000_0000_0005 -> `cnt`=0x00BB_00DD_0000_0006.
- Free-run up overflow:
  - From `cnt`=FFFF_FFFF_FFFF_FFFE, two ticks -> FFFF_FFFF_FFFF_FFFF then 0.
  - `ovf_flag` rises with the 0.
  - `irq`=1 only if `int_en[1]`=1.
- Periodic:
  - Up, `cmp`=3 -> sequence 0,1,2,3,0,1.
  - `match_flag` set on the 3→0 edge.
  - `int_clr[0]` in the same cycle as a new match leaves the flag at 1.
- One-shot down:
  - `cnt`=2 -> 1,0, then `done`=1.
  - Further ticks keep `cnt` at 0.
  - A counter write of 5 clears `done` and counting resumes.
- Halt and disable:
  - `halt`=1 with ticks -> `cnt` frozen.
  - `timer_en_neg` pulse -> `cnt`=0 with `cmp` unchanged.
  - NUM_WORDS=1 repeat of the overflow test wraps at FFFF_FFFF.
